// File: rtl/card_shoe_dealer_pkg.sv
// Shared types and constants for the blackjack card shoe.
package blackjack_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 4;

  localparam logic DEST_PLAYER = 1'b0;
  localparam logic DEST_DEALER = 1'b1;

  // Galois feedback taps for the 16-bit shuffle LFSR.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    SHUFFLE = 2'd1,
    IDLE    = 2'd2
  } state_t;

  // Card value for a rank 0..12 (ace, 2..9, ten/jack/queen/king).
  function automatic logic [CARD_W-1:0] rank_to_value(
    input logic [3:0]        rank,
    input logic [CARD_W-1:0] ace_value
  );
    logic [CARD_W-1:0] v;
    if (rank == 4'd0)      v = ace_value;
    else if (rank <= 4'd8) v = rank + 4'd1;
    else                   v = 4'd10;
    return v;
  endfunction

endpackage

// File: rtl/card_shoe_dealer_lfsr16.sv
// 16-bit right-shifting Galois LFSR, asynchronously reset to the seed.
module lfsr16
  import blackjack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // Advance one step per enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= seed;
    else if (en) state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
  end

endmodule

// File: rtl/card_shoe_dealer.sv
// 52-card shoe: fills the deck, shuffles it with an LFSR-driven
// Fisher-Yates pass and deals one card per request.
// Optional macro AUTO_RESHUFFLE_EN: an empty-deck request reshuffles and
// is then served automatically instead of raising deal_err.
module card_shoe_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned ACE_VALUE = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       deal_to,
  input  logic       shuffle_req,
  output logic       ready,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic       card_dest,
  output logic [3:0] player_card,
  output logic [3:0] dealer_card,
  output logic [5:0] cards_left,
  output logic       deal_err
);

  localparam logic [CARD_W-1:0] ACE_V    = CARD_W'(ACE_VALUE);
  localparam logic [5:0]        LAST_IDX = 6'(DECK_SIZE - 1);

  state_t            r_state, w_next;
  logic [CARD_W-1:0] r_deck [0:DECK_SIZE-1];
  logic [5:0]        r_ptr, r_fill_idx, r_i, r_cards_left;
  logic              r_card_valid, r_card_dest, r_deal_err;
  logic [3:0]        r_card_value, r_player_card, r_dealer_card;
  logic [15:0]       w_lfsr;
  logic [5:0]        w_j;
  logic              w_unused;
  logic              w_fill, w_fill_last, w_swap, w_done, w_shuf_start;
  logic              w_deal, w_deal_dest, w_err;
`ifdef AUTO_RESHUFFLE_EN
  logic              r_pend, r_pend_dest, w_pend_set;
`endif

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (r_state == SHUFFLE),
    .seed  (LFSR_SEED),
    .state (w_lfsr)
  );

  assign w_j      = w_lfsr[5:0];
  assign w_unused = ^w_lfsr[15:6];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next       = r_state;
    w_fill       = 1'b0;
    w_fill_last  = 1'b0;
    w_swap       = 1'b0;
    w_done       = 1'b0;
    w_shuf_start = 1'b0;
    w_deal       = 1'b0;
    w_deal_dest  = deal_to;
    w_err        = 1'b0;
`ifdef AUTO_RESHUFFLE_EN
    w_pend_set   = 1'b0;
`endif
    case (r_state)
      FILL: begin
        w_fill = 1'b1;
        if (r_fill_idx == LAST_IDX) begin
          w_fill_last = 1'b1;
          w_next      = SHUFFLE;
        end
      end
      SHUFFLE: begin
        if (w_j <= r_i) begin
          w_swap = 1'b1;
          if (r_i == 6'd1) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
      end
      IDLE: begin
`ifdef AUTO_RESHUFFLE_EN
        if (r_pend) begin
          w_deal      = 1'b1;
          w_deal_dest = r_pend_dest;
        end else if (shuffle_req) begin
          w_shuf_start = 1'b1;
          w_next       = SHUFFLE;
        end else if (deal_req) begin
          if (r_cards_left != '0) begin
            w_deal = 1'b1;
          end else begin
            w_shuf_start = 1'b1;
            w_pend_set   = 1'b1;
            w_next       = SHUFFLE;
          end
        end
`else
        if (shuffle_req) begin
          w_shuf_start = 1'b1;
          w_next       = SHUFFLE;
        end else if (deal_req) begin
          if (r_cards_left != '0) w_deal = 1'b1;
          else                    w_err  = 1'b1;
        end
`endif
      end
      default: w_next = FILL;
    endcase
  end

  // Deck storage: sequential fill, then in-place swaps during shuffle.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_deck[r_fill_idx] <= rank_to_value(r_fill_idx[5:2], ACE_V);
    end else if (w_swap) begin
      r_deck[r_i] <= r_deck[w_j];
      r_deck[w_j] <= r_deck[r_i];
    end
  end

  // Pointers, counters and dealt-card outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr         <= '0;
      r_fill_idx    <= '0;
      r_i           <= LAST_IDX;
      r_cards_left  <= '0;
      r_card_valid  <= 1'b0;
      r_card_value  <= '0;
      r_card_dest   <= 1'b0;
      r_player_card <= '0;
      r_dealer_card <= '0;
      r_deal_err    <= 1'b0;
    end else begin
      r_card_valid <= w_deal;
      r_deal_err   <= w_err;
      if (w_fill) r_fill_idx <= r_fill_idx + 6'd1;
      if (w_fill_last || w_shuf_start) r_i <= LAST_IDX;
      else if (w_swap)                 r_i <= r_i - 6'd1;
      if (w_shuf_start) r_cards_left <= '0;
      if (w_done) begin
        r_ptr        <= '0;
        r_cards_left <= 6'(DECK_SIZE);
      end
      if (w_deal) begin
        r_card_value <= r_deck[r_ptr];
        r_card_dest  <= w_deal_dest;
        if (w_deal_dest == DEST_DEALER) r_dealer_card <= r_deck[r_ptr];
        else                            r_player_card <= r_deck[r_ptr];
        r_ptr        <= r_ptr + 6'd1;
        r_cards_left <= r_cards_left - 6'd1;
      end
    end
  end

`ifdef AUTO_RESHUFFLE_EN
  // Latched empty-deck request, served on the first IDLE cycle after reshuffle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend      <= 1'b0;
      r_pend_dest <= 1'b0;
    end else if (w_pend_set) begin
      r_pend      <= 1'b1;
      r_pend_dest <= deal_to;
    end else if (w_deal) begin
      r_pend      <= 1'b0;
    end
  end

  // The pending request owns the first IDLE cycle, so new requests wait.
  assign ready = (r_state == IDLE) && (r_cards_left != '0) && !r_pend;
`else
  assign ready = (r_state == IDLE) && (r_cards_left != '0);
`endif

  assign busy        = (r_state != IDLE);
  assign card_valid  = r_card_valid;
  assign card_value  = r_card_value;
  assign card_dest   = r_card_dest;
  assign player_card = r_player_card;
  assign dealer_card = r_dealer_card;
  assign cards_left  = r_cards_left;
  assign deal_err    = r_deal_err;

endmodule

// File: doc/card_shoe_dealer.md
Name: card_shoe_dealer

Overview:
- Card source for blackjack_game: holds a 52-card deck, shuffles it with an LFSR-driven Fisher-Yates pass, and deals one card per request.
- Drives blackjack_game's player_card / dealer_card inputs.
- Replaces bench-generated random cards with a synthesizable, deck-accurate shoe with a request/valid handshake.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR state; 0 is illegal.
- ACE_VALUE, 11, value emitted for an ace; legal values 1 or 11.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- deal_req  in  1  request one card; sampled only when ready=1
- deal_to  in  1  destination for the request: 0 = player, 1 = dealer
- shuffle_req  in  1  reshuffle the full deck; sampled in IDLE
- ready  out  1  high in IDLE with cards_left>0
- busy  out  1  high in FILL or SHUFFLE
- card_valid  out  1  one-cycle pulse per dealt card
- card_value  out  4  dealt card (2..10 or ACE_VALUE); held between pulses
- card_dest  out  1  deal_to of the dealt card
- player_card  out  4  last card dealt to the player; feeds blackjack_game
- dealer_card  out  4  last card dealt to the dealer; feeds blackjack_game
- cards_left  out  6  undealt cards, 0..52
- deal_err  out  1  one-cycle pulse: request arrived with deck empty (feature off only)

Behaviour:
- Reset (asynchronous, immediate, any state) forces:
  - state=FILL, ptr=0, fill index=0, LFSR=LFSR_SEED
  - card_valid=0, card_value=0, card_dest=0, player_card=0, dealer_card=0
  - cards_left=0, ready=0, busy=1, deal_err=0
- FILL, 52 cycles: deck[k] gets the value of rank r=k/4:
  - r=0 -> ACE_VALUE
  - r=1..8 -> r+1
  - r=9..12 -> 10
  - After k=51, go to SHUFFLE with i=51.
- SHUFFLE: the 16-bit Galois LFSR (mask 16'hB400) advances every SHUFFLE cycle and only then. Each cycle, j=lfsr[5:0]:
  - j>i: reject, nothing else changes.
  - j<=i: swap deck[i] and deck[j] in the same cycle, then i-=1.
  - When i reaches 0: go to IDLE with ptr=0 and cards_left=52.
- Duration is data-dependent but deterministic for a given seed.
- IDLE priority per cycle:
  1. shuffle_req -> SHUFFLE with i=51, cards_left=0. A deal_req in the same cycle is dropped. The deck is reshuffled in place, with no refill.
  2. deal_req with cards_left>0:
     - Next edge: card_valid=1, card_value=deck[ptr], card_dest=deal_to.
     - player_card or dealer_card (selected by deal_to) is loaded with deck[ptr]; the other holds.
     - ptr+=1, cards_left-=1.
     - Latency: 1 cycle from request to card_valid.
  3. deal_req with cards_left=0 -> see Optional Feature.
- Back-to-back requests are accepted every cycle, so deal_req held high for N cycles yields N cards. There is no request queue.
- deal_req while busy: ignored, with no card_valid and no deal_err.
- shuffle_req outside IDLE: ignored.
- ready and busy are combinational decodes of registered state.

Optional Feature:
- Macro AUTO_RESHUFFLE_EN.
- Defined:
  - A deal_req with cards_left=0 latches deal_to, enters SHUFFLE, and on return to IDLE automatically serves the latched request.
  - That request's card_valid is the first event after SHUFFLE completes; cards_left ends at 51.
  - deal_err is tied to 0.
- Undefined:
  - The empty-deck request is dropped and deal_err pulses one cycle on the next edge.
  - The state stays IDLE; only shuffle_req recovers.

Decomposition:
- blackjack_pkg:
  - DECK_SIZE=52, CARD_W=4
  - DEST_PLAYER=0, DEST_DEALER=1
  - state enum {FILL, SHUFFLE, IDLE}
  - function rank_to_value(rank, ace_value)
  - LFSR mask constant 16'hB400
- One sub-module: lfsr16, with ports clk, reset, en, seed, state, giving a Galois LFSR with async reset to the seed.
- The deck array, pointer and FSM stay in card_shoe_dealer.

Test Plan:
- Reset released -> busy=1 for exactly 52 FILL cycles plus the SHUFFLE cycles, then ready=1, cards_left=52, all card outputs 0.
- 52 back-to-back deal_req with alternating deal_to -> 52 card_valid pulses. The multiset is 4x ACE_VALUE(11), 4 each of 2..9 and 16x 10; the sum is 380; cards_left=0, ready=0.
- Single deal_req with deal_to=1 at cycle t -> card_valid only at t+1; dealer_card=card_value, player_card unchanged, cards_left=51.
- deal_req with cards_left=0:
  - Feature off -> deal_err pulse, no card_valid, cards_left=0.
  - Feature on -> busy, then a card_valid with the latched card_dest, cards_left=51.
- Reset asserted mid-SHUFFLE -> outputs take their reset values without a clock edge. After release, the first 10 dealt cards are identical to the first post-reset run (same seed).
- shuffle_req and deal_req in the same IDLE cycle with cards_left=40 -> no card_valid, busy=1, then ready with cards_left=52 and a valid deck multiset.
